occamy_intr_gateway: RTL and testbench
======================================

Name: occamy_intr_gateway

Overview:
- Consumer side of the SoC interrupt lines: collects level interrupts (for example intr_ecc_correctable/uncorrectable) from several producers.
- Gates each source through an IDLE/PENDING/CLAIMED handshake so a level source is delivered once per service.
- Arbitrates pending sources by fixed priority and drives one interrupt request to the core.
- The core's claim/complete accesses are presented as single-cycle pulses by the core-side register block.

Parameters:
- NumSrc, 8, number of interrupt sources (1..31).
- IdWidth, $clog2(NumSrc+1), width of source IDs. ID 0 means "none"; source i has ID i+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- intr_i  in  NumSrc  source interrupt lines, level-sensitive, synchronous to clk_i.
- enable_i  in  NumSrc  per-source enable.
- irq_o  out  1  interrupt request to core.
- claim_i  in  1  claim pulse.
- claim_id_o  out  IdWidth  claimed ID, valid while claim_valid_o is high.
- claim_valid_o  out  1  one-cycle pulse returning the claim result.
- complete_i  in  1  completion pulse.
- complete_id_i  in  IdWidth  ID being completed.
- pending_o  out  NumSrc  per-source PENDING status.
- err_o  out  1  sticky error flag; set on a complete to a source that is not CLAIMED, or to ID 0 or an ID above NumSrc.

Behaviour:
- Reset: all sources IDLE; irq_o=0, claim_valid_o=0, claim_id_o=0, pending_o=0, err_o=0. Reset mid-operation drops every pending or claimed state immediately.
- Per-source FSM, updated on the rising edge:
  - IDLE -> PENDING when intr_i[i]=1. This happens regardless of enable_i; enable only masks arbitration.
  - PENDING -> CLAIMED when this source wins a claim.
  - CLAIMED -> IDLE on complete_i with complete_id_i=i+1.
  - While CLAIMED, intr_i is ignored. A level still high after complete re-pends on the next cycle (IDLE sees intr_i=1).
- pending_o[i] = (state==PENDING), registered.
- Arbitration is combinational over PENDING & enable_i; the lowest index wins.
- irq_o is registered: irq_o(t+1) = |(PENDING & enable_i) at t. Latency from intr_i rising to irq_o is 2 cycles (IDLE->PENDING, then irq register).
- Claim: claim_i at cycle t:
  - claim_valid_o=1 at t+1.
  - claim_id_o = winner ID at t, or 0 if no enabled pending source.
  - The winner moves to CLAIMED at t+1.
  - claim_id_o holds its value until the next claim.
- A claim with nothing pending returns ID 0 and changes no state.
- Complete to a source that is not CLAIMED, or to an invalid ID: ignored, and err_o set. err_o stays set until reset.
- Simultaneous claim_i and complete_i in one cycle are both processed.
  - If the completed source is the same one being claimed, it cannot be, since it is CLAIMED, not PENDING. The complete takes effect and the claim uses the PENDING set of that cycle.
- Back-to-back claims on consecutive cycles are legal; each sees state already updated by the previous claim.
- Disabling a PENDING source keeps it PENDING; it is not arbitrated until re-enabled.
- A CLAIMED source remains claimable-to-complete regardless of enable_i.

Optional Feature:
- Macro: OCCAMY_INTR_GW_EDGE_EN.
- When defined:
  - Adds input edge_i [NumSrc] (1 = rising-edge source) and a registered copy of intr_i.
  - An edge source goes IDLE->PENDING on a 0->1 transition of intr_i, not on level.
  - A rising edge arriving while the source is PENDING is absorbed.
  - A rising edge arriving while CLAIMED sets a per-source replay bit. On complete, the source goes to PENDING instead of IDLE and the replay bit clears.
  - The edge-detect register resets to 0, so a line held high through reset release counts as an edge.
- When undefined: no edge_i port, no edge/replay state, all sources level-sensitive as above.

Test Plan:
- Reset release, intr_i=8'h00, enable_i=8'hFF -> irq_o=0 and pending_o=0 for 10 cycles; claim_i returns claim_id_o=0, claim_valid_o one cycle later.
- intr_i[3]=1 at cycle 5 -> pending_o[3]=1 at 6, irq_o=1 at 7; claim at 8 -> claim_id_o=4 at 9, pending_o[3]=0, irq_o=0 at 10; complete ID 4 with intr_i[3] still 1 -> re-pending one cycle later.
- intr_i=8'b1010_0100, enable_i=8'hFB -> successive claims return IDs 6, 8, 0 (source 2 masked); enabling bit 2 then claiming returns ID 3.
- Same cycle: claim_i plus complete_i for ID 2 (CLAIMED), with sources 0 and 5 pending -> claim returns 1; source 1 goes IDLE; err_o stays 0.
- complete_id_i=0, then complete_id_i=9 (NumSrc=8), then a complete to an IDLE source -> err_o=1 after the first and remains 1; no FSM state changes.
- EDGE_EN build, edge_i[0]=1: pulse intr_i[0], claim (ID 1), pulse again while CLAIMED, complete -> pending_o[0]=1 the next cycle; second claim returns 1; assert rst_i mid-claim -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/occamy_intr_gateway_if.sv
// Bundle between the core-side register block / interrupt fabric and the gateway.
// The gateway uses the slave modport. Define OCCAMY_INTR_GW_EDGE_EN to add per-source edge_i.
interface occamy_intr_gateway_if #(
    parameter int NumSrc  = 8,
    parameter int IdWidth = $clog2(NumSrc + 1)
);
    // claim_i and complete_i are single-cycle pulses. claim_valid_o pulses the cycle after
    // claim_i. claim_id_o is valid with claim_valid_o and holds until the next claim.
    // Neither pulse can be back-pressured, so there is no ready signal.
    logic [NumSrc-1:0]    intr_i;
    logic [NumSrc-1:0]    enable_i;
`ifdef OCCAMY_INTR_GW_EDGE_EN
    logic [NumSrc-1:0]    edge_i;
`endif
    logic                 irq_o;
    logic                 claim_i;
    logic [IdWidth-1:0]   claim_id_o;
    logic                 claim_valid_o;
    logic                 complete_i;
    logic [IdWidth-1:0]   complete_id_i;
    logic [NumSrc-1:0]    pending_o;
    logic                 err_o;
    logic [2*NumSrc-1:0]  state_dbg_o;

`ifdef OCCAMY_INTR_GW_EDGE_EN
    modport slave (
        input  intr_i, enable_i, edge_i, claim_i, complete_i, complete_id_i,
        output irq_o, claim_id_o, claim_valid_o, pending_o, err_o, state_dbg_o
    );
    modport master (
        output intr_i, enable_i, edge_i, claim_i, complete_i, complete_id_i,
        input  irq_o, claim_id_o, claim_valid_o, pending_o, err_o, state_dbg_o
    );
`else
    modport slave (
        input  intr_i, enable_i, claim_i, complete_i, complete_id_i,
        output irq_o, claim_id_o, claim_valid_o, pending_o, err_o, state_dbg_o
    );
    modport master (
        output intr_i, enable_i, claim_i, complete_i, complete_id_i,
        input  irq_o, claim_id_o, claim_valid_o, pending_o, err_o, state_dbg_o
    );
`endif
endinterface

// File: rtl/occamy_intr_gateway.sv
// Interrupt gateway: per-source IDLE/PENDING/CLAIMED gating, with fixed-priority claim arbitration.
// Optional rising-edge sources with replay, enabled by the macro OCCAMY_INTR_GW_EDGE_EN.
module occamy_intr_gateway #(
    parameter int NumSrc  = 8,
    parameter int IdWidth = $clog2(NumSrc + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    occamy_intr_gateway_if.slave gw_if
);
    typedef enum logic [1:0] {
        SrcIdle    = 2'd0,
        SrcPending = 2'd1,
        SrcClaimed = 2'd2
    } src_state_e;

    src_state_e          state_q [NumSrc];
    src_state_e          state_d [NumSrc];
    logic [NumSrc-1:0]   pending_vec;
    logic [NumSrc-1:0]   arb_vec;
    logic [NumSrc-1:0]   fire_vec;
    logic                win_found;
    logic [IdWidth-1:0]  win_id;
    logic                complete_hit;
    logic                irq_q, irq_d;
    logic                claim_valid_q, claim_valid_d;
    logic [IdWidth-1:0]  claim_id_q, claim_id_d;
    logic                err_q, err_d;
`ifdef OCCAMY_INTR_GW_EDGE_EN
    logic [NumSrc-1:0]   intr_q;
    logic [NumSrc-1:0]   rise_vec;
    logic [NumSrc-1:0]   replay_q, replay_d;
`endif

    always_comb begin
        pending_vec = '0;
        for (int i = 0; i < NumSrc; i++) begin
            pending_vec[i] = (state_q[i] == SrcPending);
        end
    end

    assign arb_vec = pending_vec & gw_if.enable_i;

    // Fixed priority: the lowest index among enabled pending sources wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (arb_vec[i] && !win_found) begin
                win_found = 1'b1;
                win_id    = IdWidth'(i + 1);
            end
        end
    end

`ifdef OCCAMY_INTR_GW_EDGE_EN
    assign rise_vec = gw_if.intr_i & ~intr_q;
    assign fire_vec = (gw_if.edge_i & rise_vec) | (~gw_if.edge_i & gw_if.intr_i);
`else
    assign fire_vec = gw_if.intr_i;
`endif

    always_comb begin
        complete_hit  = 1'b0;
        err_d         = err_q;
        irq_d         = |arb_vec;
        claim_valid_d = gw_if.claim_i;
        claim_id_d    = gw_if.claim_i ? win_id : claim_id_q;
`ifdef OCCAMY_INTR_GW_EDGE_EN
        replay_d      = replay_q;
`endif
        for (int i = 0; i < NumSrc; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                SrcIdle: begin
                    if (fire_vec[i]) state_d[i] = SrcPending;
                end
                SrcPending: begin
                    if (gw_if.claim_i && win_found && (win_id == IdWidth'(i + 1))) begin
                        state_d[i] = SrcClaimed;
                    end
                end
                SrcClaimed: begin
`ifdef OCCAMY_INTR_GW_EDGE_EN
                    if (gw_if.edge_i[i] && rise_vec[i]) replay_d[i] = 1'b1;
`endif
                    if (gw_if.complete_i && (gw_if.complete_id_i == IdWidth'(i + 1))) begin
                        complete_hit = 1'b1;
`ifdef OCCAMY_INTR_GW_EDGE_EN
                        // An edge caught during service replays straight back to PENDING.
                        state_d[i]  = (gw_if.edge_i[i] && (replay_q[i] || rise_vec[i]))
                                      ? SrcPending : SrcIdle;
                        replay_d[i] = 1'b0;
`else
                        state_d[i]  = SrcIdle;
`endif
                    end
                end
                default: state_d[i] = SrcIdle;
            endcase
        end
        // Invalid IDs never match any source, so they fall out here as well.
        if (gw_if.complete_i && !complete_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSrc; i++) begin
                state_q[i] <= SrcIdle;
            end
            irq_q         <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            err_q         <= 1'b0;
`ifdef OCCAMY_INTR_GW_EDGE_EN
            intr_q        <= '0;
            replay_q      <= '0;
`endif
        end else begin
            for (int i = 0; i < NumSrc; i++) begin
                state_q[i] <= state_d[i];
            end
            irq_q         <= irq_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            err_q         <= err_d;
`ifdef OCCAMY_INTR_GW_EDGE_EN
            intr_q        <= gw_if.intr_i;
            replay_q      <= replay_d;
`endif
        end
    end

    always_comb begin
        gw_if.state_dbg_o = '0;
        for (int i = 0; i < NumSrc; i++) begin
            gw_if.state_dbg_o[2*i +: 2] = state_q[i];
        end
    end

    assign gw_if.irq_o         = irq_q;
    assign gw_if.claim_valid_o = claim_valid_q;
    assign gw_if.claim_id_o    = claim_id_q;
    assign gw_if.pending_o     = pending_vec;
    assign gw_if.err_o         = err_q;
endmodule

// File: tb/tb_occamy_intr_gateway.sv
// Bench for occamy_intr_gateway: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a set-based behavioural model.
module tb_occamy_intr_gateway;
    localparam int N = 8;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    occamy_intr_gateway_if #(.NumSrc(N), .IdWidth(W)) gw();
    occamy_intr_gateway #(.NumSrc(N), .IdWidth(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .gw_if (gw)
    );

    logic [N-1:0] tb_edge = '0;
`ifdef OCCAMY_INTR_GW_EDGE_EN
    assign gw.edge_i = tb_edge;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: sets of pending / claimed sources, plus edge history and replay flags.
    logic [N-1:0] m_pend, m_claim, m_prev, m_replay;
    logic         m_irq, m_cv, m_err;
    logic [W-1:0] m_cid;
    logic [N-1:0] nx_pend, nx_claim, nx_replay, avail, rise, fire;
    logic         nx_irq, nx_err;
    logic [W-1:0] win, nx_cid;
    int           k, wk;

    always_comb begin
        avail = m_pend & gw.enable_i;
        win   = '0;
        for (int i = N - 1; i >= 0; i--) if (avail[i]) win = W'(i + 1);
        rise      = gw.intr_i & ~m_prev;
        fire      = (tb_edge & rise) | (~tb_edge & gw.intr_i);
        nx_pend   = m_pend | (~m_pend & ~m_claim & fire);
        nx_claim  = m_claim;
        nx_replay = m_replay | (m_claim & tb_edge & rise);
        nx_err    = m_err;
        k         = int'(gw.complete_id_i) - 1;
        wk        = int'(win) - 1;
        if (gw.complete_i) begin
            if (k >= 0 && k < N && m_claim[k]) begin
                nx_claim[k]  = 1'b0;
                nx_replay[k] = 1'b0;
                if (tb_edge[k] && (m_replay[k] || rise[k])) nx_pend[k] = 1'b1;
            end else begin
                nx_err = 1'b1;
            end
        end
        if (gw.claim_i && wk >= 0) begin
            nx_pend[wk]  = 1'b0;
            nx_claim[wk] = 1'b1;
        end
        nx_irq = |avail;
        nx_cid = gw.claim_i ? win : m_cid;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= '0; m_claim <= '0; m_prev <= '0; m_replay <= '0;
            m_irq <= 1'b0; m_cv <= 1'b0; m_err <= 1'b0; m_cid <= '0;
        end else begin
            m_pend <= nx_pend; m_claim <= nx_claim; m_prev <= gw.intr_i; m_replay <= nx_replay;
            m_irq <= nx_irq; m_cv <= gw.claim_i; m_err <= nx_err; m_cid <= nx_cid;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("model_irq", 32'(gw.irq_o), 32'(m_irq));
            chk("model_pending", 32'(gw.pending_o), 32'(m_pend));
            chk("model_claim_valid", 32'(gw.claim_valid_o), 32'(m_cv));
            if (m_cv) chk("model_claim_id", 32'(gw.claim_id_o), 32'(m_cid));
            chk("model_err", 32'(gw.err_o), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_claim();
        gw.claim_i = 1'b1;
        tick();
        gw.claim_i = 1'b0;
    endtask

    task automatic do_complete(input logic [W-1:0] id);
        gw.complete_i    = 1'b1;
        gw.complete_id_i = id;
        tick();
        gw.complete_i    = 1'b0;
    endtask

    task automatic pick_claimed(output logic [W-1:0] id);
        int s;
        s  = $urandom_range(0, N - 1);
        id = W'(s + 1);
        for (int j = 0; j < N; j++) begin
            if (m_claim[(s + j) % N]) begin
                id = W'((s + j) % N + 1);
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] cid;
        rst = 1'b1;
        gw.intr_i = '0; gw.enable_i = 8'hFF; gw.claim_i = 1'b0;
        gw.complete_i = 1'b0; gw.complete_id_i = '0;
        chk_on = 1'b1;
        #12;
        chk("rst_irq", 32'(gw.irq_o), 0);
        chk("rst_pending", 32'(gw.pending_o), 0);
        chk("rst_claim_valid", 32'(gw.claim_valid_o), 0);
        chk("rst_err", 32'(gw.err_o), 0);
        tick();
        rst = 1'b0;

        // Idle after reset, then an empty claim.
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_irq", 32'(gw.irq_o), 0);
            chk("idle_pending", 32'(gw.pending_o), 0);
        end
        do_claim();
        chk("empty_claim_valid", 32'(gw.claim_valid_o), 1);
        chk("empty_claim_id", 32'(gw.claim_id_o), 0);
        tick();
        chk("empty_claim_valid_drop", 32'(gw.claim_valid_o), 0);

        // Single level source: latency, claim, complete with the line still high.
        gw.intr_i = 8'h08;
        tick();
        chk("lat_pending3", 32'(gw.pending_o[3]), 1);
        chk("lat_irq_early", 32'(gw.irq_o), 0);
        tick();
        chk("lat_irq", 32'(gw.irq_o), 1);
        do_claim();
        chk("claim4_id", 32'(gw.claim_id_o), 4);
        chk("claim4_pending", 32'(gw.pending_o[3]), 0);
        tick();
        chk("claim4_irq_drop", 32'(gw.irq_o), 0);
        chk("claim4_id_hold", 32'(gw.claim_id_o), 4);
        do_complete(4'd4);
        chk("repend_not_yet", 32'(gw.pending_o[3]), 0);
        tick();
        chk("repend", 32'(gw.pending_o[3]), 1);
        gw.intr_i = '0;
        do_claim();
        do_complete(4'd4);

        // Priority with a masked source, back-to-back claims.
        gw.intr_i = 8'b1010_0100; gw.enable_i = 8'hFB;
        tick();
        gw.claim_i = 1'b1;
        tick();
        chk("prio_first", 32'(gw.claim_id_o), 6);
        tick();
        chk("prio_second", 32'(gw.claim_id_o), 8);
        tick();
        chk("prio_none", 32'(gw.claim_id_o), 0);
        chk("prio_none_valid", 32'(gw.claim_valid_o), 1);
        gw.claim_i = 1'b0;
        gw.intr_i = '0; gw.enable_i = 8'hFF;
        do_claim();
        chk("prio_unmasked", 32'(gw.claim_id_o), 3);
        do_complete(4'd6); do_complete(4'd8); do_complete(4'd3);
        chk("prio_err", 32'(gw.err_o), 0);

        // Claim and complete in the same cycle.
        gw.intr_i = 8'h02;
        tick();
        gw.intr_i = '0;
        do_claim();
        chk("sim_pre_claim", 32'(gw.claim_id_o), 2);
        gw.intr_i = 8'h21;
        tick();
        gw.intr_i = '0;
        gw.claim_i = 1'b1; gw.complete_i = 1'b1; gw.complete_id_i = 4'd2;
        tick();
        gw.claim_i = 1'b0; gw.complete_i = 1'b0;
        chk("sim_claim_id", 32'(gw.claim_id_o), 1);
        chk("sim_err", 32'(gw.err_o), 0);
        chk("sim_pending", 32'(gw.pending_o), 32'h20);
        tick();
        chk("sim_src1_idle", 32'(gw.pending_o), 32'h20);
        do_complete(4'd1);
        do_claim();
        chk("sim_last_claim", 32'(gw.claim_id_o), 6);
        do_complete(4'd6);

        // Illegal completes: ID 0, out-of-range ID, non-claimed sources.
        gw.intr_i = 8'h10;
        tick();
        gw.intr_i = '0;
        do_complete(4'd0);
        chk("err_id0", 32'(gw.err_o), 1);
        do_complete(4'd9);
        do_complete(4'd3);
        do_complete(4'd5);
        chk("err_sticky", 32'(gw.err_o), 1);
        chk("err_no_change", 32'(gw.pending_o), 32'h10);
        do_claim();
        chk("err_claim_intact", 32'(gw.claim_id_o), 5);
        do_complete(4'd5);
        tick();
        chk("err_still_set", 32'(gw.err_o), 1);
        do_reset();

`ifdef OCCAMY_INTR_GW_EDGE_EN
        // Edge source with replay, then a reset asserted mid-claim.
        tb_edge = 8'h01;
        gw.intr_i = 8'h01;
        tick();
        gw.intr_i = '0;
        chk("edge_pending", 32'(gw.pending_o[0]), 1);
        do_claim();
        chk("edge_claim1", 32'(gw.claim_id_o), 1);
        gw.intr_i = 8'h01;
        tick();
        gw.intr_i = '0;
        chk("edge_absorbed_while_claimed", 32'(gw.pending_o[0]), 0);
        do_complete(4'd1);
        chk("edge_replay", 32'(gw.pending_o[0]), 1);
        do_claim();
        chk("edge_claim2", 32'(gw.claim_id_o), 1);
        do_complete(4'd1);
        chk("edge_no_replay", 32'(gw.pending_o[0]), 0);
        gw.intr_i = 8'h01;
        tick();
        gw.claim_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_irq", 32'(gw.irq_o), 0);
        chk("async_rst_valid", 32'(gw.claim_valid_o), 0);
        chk("async_rst_id", 32'(gw.claim_id_o), 0);
        chk("async_rst_pending", 32'(gw.pending_o), 0);
        chk("async_rst_err", 32'(gw.err_o), 0);
        gw.claim_i = 1'b0;
        gw.intr_i = '0;
        tick();
        rst = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) begin
                rst = 1'b1;
`ifdef OCCAMY_INTR_GW_EDGE_EN
                tb_edge = N'($urandom);
`endif
                tick();
                rst = 1'b0;
            end
            gw.intr_i   = N'($urandom & $urandom & $urandom);
            gw.enable_i = N'(~($urandom & $urandom & $urandom));
            gw.claim_i  = ($urandom_range(0, 2) == 0);
            gw.complete_i = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                gw.complete_i = 1'b1;
                if ($urandom_range(0, 19) == 0) gw.complete_id_i = W'($urandom_range(0, 15));
                else begin
                    pick_claimed(cid);
                    gw.complete_id_i = cid;
                end
            end
            tick();
        end
        gw.claim_i = 1'b0; gw.complete_i = 1'b0;
        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
